// File: rtl/vinstr_issue_queue.sv
// vinstr_issue_queue: small instruction FIFO feeding the vector decoder.
// Drops instructions whose major opcode is not a vector opcode. Issues legal
// instructions with a one-cycle start strobe. Enforces ISSUE_GAP idle cycles
// between issues.
//
// Ports:
//   clk, rstn            rising-edge clock, synchronous active-low reset
//   flush                synchronous clear of queue and FSM (keeps illegal_count)
//   in_valid/in_instr    upstream instruction handshake
//   in_ready             queue not full (from registered occupancy)
//   dec_ready            decoder can take a new instruction (sampled in IDLE only)
//   vector_instruction   last issued instruction; valid while start=1
//   start                one-cycle issue strobe
//   busy                 FSM not idle or queue not empty
//   count                FIFO occupancy
//   illegal              one-cycle pulse per dropped instruction
//   illegal_count        saturating count of dropped instructions
module vinstr_issue_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned IW        = 32,
    parameter int unsigned ISSUE_GAP = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [IW-1:0]                in_instr,
    output logic                         in_ready,
    input  logic                         dec_ready,
    output logic [IW-1:0]                vector_instruction,
    output logic                         start,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         illegal,
    output logic [7:0]                   illegal_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned GW = 4;

    localparam logic [6:0] OPC_V     = 7'b1010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000111;
    localparam logic [6:0] OPC_STORE = 7'b0100111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     gap_q, gap_d;

    logic [IW-1:0]     mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;

    logic              in_ready_q, busy_q, start_q, illegal_q;
    logic [IW-1:0]     vec_q, vec_d;
    logic [7:0]        ill_cnt_q, ill_cnt_d;
    logic              start_d, illegal_d;

    logic [IW-1:0]     head;
    logic              head_legal;
    logic              push;
    logic              pop;

    assign head       = mem[rd_ptr_q];
    assign head_legal = (head[6:0] == OPC_V) || (head[6:0] == OPC_LOAD) ||
                        (head[6:0] == OPC_STORE);

    // in_ready is registered, so push never depends on dec_ready combinationally
    assign push = in_valid && in_ready_q;
    // The FSM examines and consumes the head only from IDLE
    assign pop  = (state_q == ST_IDLE) && (count_q != '0) && dec_ready;

    assign count_d = count_q + CW'(push) - CW'(pop);

    // FSM state register (with gap counter)
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop && head_legal) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = (ISSUE_GAP == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (gap_q <= GW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output / datapath next values
    always_comb begin
        gap_d     = gap_q;
        start_d   = 1'b0;
        illegal_d = 1'b0;
        vec_d     = vec_q;
        ill_cnt_d = ill_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    if (head_legal) begin
                        start_d = 1'b1;
                        vec_d   = head;
                    end else begin
                        illegal_d = 1'b1;
                        if (ill_cnt_q != 8'hFF) begin
                            ill_cnt_d = ill_cnt_q + 8'd1;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                gap_d = GW'(ISSUE_GAP);
            end
            ST_GAP: begin
                gap_d = gap_q - GW'(1);
            end
            default: begin
                gap_d = '0;
            end
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (rstn && !flush && push) begin
            mem[wr_ptr_q] <= in_instr;
        end
    end

    // Registered outputs; flush clears everything except illegal_count
    always_ff @(posedge clk) begin
        if (!rstn) begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            illegal_q  <= 1'b0;
            vec_q      <= '0;
            ill_cnt_q  <= '0;
        end else if (flush) begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            illegal_q  <= 1'b0;
            vec_q      <= '0;
        end else begin
            in_ready_q <= (count_d != CW'(DEPTH));
            busy_q     <= (state_d != ST_IDLE) || (count_d != '0);
            start_q    <= start_d;
            illegal_q  <= illegal_d;
            vec_q      <= vec_d;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign in_ready           = in_ready_q;
    assign busy               = busy_q;
    assign start              = start_q;
    assign illegal            = illegal_q;
    assign vector_instruction = vec_q;
    assign illegal_count      = ill_cnt_q;
    assign count              = count_q;

endmodule

// File: tb/tb_vinstr_issue_queue.sv
// Directed, table-driven bench for vinstr_issue_queue (DEPTH=4, ISSUE_GAP=2).
module tb_vinstr_issue_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = 32;
    localparam int unsigned GAP   = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rstn, flush, in_valid, in_ready, dec_ready;
    logic [IW-1:0]   in_instr, vector_instruction;
    logic            start, busy, illegal;
    logic [CW-1:0]   count;
    logic [7:0]      illegal_count;

    vinstr_issue_queue #(.DEPTH(DEPTH), .IW(IW), .ISSUE_GAP(GAP)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .dec_ready(dec_ready), .vector_instruction(vector_instruction),
        .start(start), .busy(busy), .count(count),
        .illegal(illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic        dr;
        logic        fl;
        logic        e_start;
        logic [31:0] e_vec;
        logic [2:0]  e_count;
        logic        e_rdy;
        logic        e_busy;
        logic        e_ill;
        logic [7:0]  e_icnt;
    } vec_t;

    vec_t tv[$];
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] V0 = 32'h0221_8057;
    localparam logic [31:0] IA = 32'h1110_0057;
    localparam logic [31:0] IB = 32'h2220_0027;
    localparam logic [31:0] IC = 32'h3330_0007;
    localparam logic [31:0] ID = 32'h4440_0057;
    localparam logic [31:0] IE = 32'h5550_0027;

    function automatic void add(input logic v, input logic [31:0] instr, input logic dr,
                                input logic fl, input logic st, input logic [31:0] vc,
                                input int cnt, input logic rdy, input logic bsy,
                                input logic ill, input int icnt);
        vec_t r;
        r.v = v; r.instr = instr; r.dr = dr; r.fl = fl;
        r.e_start = st; r.e_vec = vc; r.e_count = 3'(cnt); r.e_rdy = rdy;
        r.e_busy = bsy; r.e_ill = ill; r.e_icnt = 8'(icnt);
        tv.push_back(r);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic st,
                           input logic [31:0] vc, input int cnt, input logic rdy,
                           input logic bsy, input logic ill, input int icnt);
        chk({tag, "_start"}, idx, 32'(start), 32'(st));
        chk({tag, "_vec"},   idx, vector_instruction, vc);
        chk({tag, "_count"}, idx, 32'(count), 32'(cnt));
        chk({tag, "_rdy"},   idx, 32'(in_ready), 32'(rdy));
        chk({tag, "_busy"},  idx, 32'(busy), 32'(bsy));
        chk({tag, "_ill"},   idx, 32'(illegal), 32'(ill));
        chk({tag, "_icnt"},  idx, 32'(illegal_count), 32'(icnt));
    endtask

    initial begin
        logic [31:0] seqv [4];
        seqv[0] = IB; seqv[1] = IC; seqv[2] = ID; seqv[3] = IE;

        // single issue latency and gap
        add(1, V0, 1, 0, 0, 0,  1, 1, 1, 0, 0);
        add(0, 0,  1, 0, 1, V0, 0, 1, 1, 0, 0);
        add(0, 0,  1, 0, 0, V0, 0, 1, 1, 0, 0);
        add(0, 0,  1, 0, 0, V0, 0, 1, 1, 0, 0);
        add(0, 0,  1, 0, 0, V0, 0, 1, 0, 0, 0);
        // illegal filtering: 0x33 dropped, 0x07 issued
        add(1, 32'h33, 1, 0, 0, V0,    1, 1, 1, 0, 0);
        add(1, 32'h07, 1, 0, 0, V0,    1, 1, 1, 1, 1);
        add(0, 0,      1, 0, 1, 32'h7, 0, 1, 1, 0, 1);
        add(0, 0,      1, 0, 0, 32'h7, 0, 1, 1, 0, 1);
        add(0, 0,      1, 0, 0, 32'h7, 0, 1, 1, 0, 1);
        add(0, 0,      1, 0, 0, 32'h7, 0, 1, 0, 0, 1);
        // fill with decoder stalled, then drain
        add(1, IA, 0, 0, 0, 32'h7, 1, 1, 1, 0, 1);
        add(1, IB, 0, 0, 0, 32'h7, 2, 1, 1, 0, 1);
        add(1, IC, 0, 0, 0, 32'h7, 3, 1, 1, 0, 1);
        add(1, ID, 0, 0, 0, 32'h7, 4, 0, 1, 0, 1);
        add(1, IE, 0, 0, 0, 32'h7, 4, 0, 1, 0, 1);
        add(1, IE, 1, 0, 1, IA,    3, 1, 1, 0, 1);
        add(1, IE, 1, 0, 0, IA,    4, 0, 1, 0, 1);
        add(0, 0,  1, 0, 0, IA,    4, 0, 1, 0, 1);
        add(0, 0,  1, 0, 0, IA,    4, 0, 1, 0, 1);
        add(0, 0,  1, 0, 1, IB,    3, 1, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) add(0, 0, 1, 0, 0, seqv[k], 3 - k, 1, 1, 0, 1);
            add(0, 0, 1, 0, 1, seqv[k+1], 2 - k, 1, 1, 0, 1);
        end
        add(0, 0, 1, 0, 0, IE, 0, 1, 1, 0, 1);
        add(0, 0, 1, 0, 0, IE, 0, 1, 1, 0, 1);
        add(0, 0, 1, 0, 0, IE, 0, 1, 0, 0, 1);
        // flush with simultaneous push at count=3
        add(1, 32'h57,       0, 0, 0, IE, 1, 1, 1, 0, 1);
        add(1, 32'h57,       0, 0, 0, IE, 2, 1, 1, 0, 1);
        add(1, 32'h57,       0, 0, 0, IE, 3, 1, 1, 0, 1);
        add(1, 32'h6660_0057, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        add(0, 0,            1, 0, 0, 0,  0, 1, 0, 0, 1);
        add(0, 0,            1, 0, 0, 0,  0, 1, 0, 0, 1);

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; dec_ready = 1'b0;
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 1, 0, 0, 0);

        rstn = 1'b1;
        foreach (tv[i]) begin
            flush = tv[i].fl; in_valid = tv[i].v; in_instr = tv[i].instr;
            dec_ready = tv[i].dr;
            step();
            chk_all("tv", i, tv[i].e_start, tv[i].e_vec, int'(tv[i].e_count),
                    tv[i].e_rdy, tv[i].e_busy, tv[i].e_ill, int'(tv[i].e_icnt));
        end
        flush = 1'b0;

        // reset in the middle of a gap
        in_valid = 1'b1; in_instr = 32'h57; dec_ready = 1'b1;
        step();
        chk("mg_count", 0, 32'(count), 32'd1);
        in_valid = 1'b0;
        step();
        chk("mg_start", 0, 32'(start), 32'd1);
        chk("mg_vec", 0, vector_instruction, 32'h57);
        step();
        chk("mg_busy", 0, 32'(busy), 32'd1);
        rstn = 1'b0;
        step();
        chk_all("mgrst", 0, 0, 0, 0, 1, 0, 0, 0);
        rstn = 1'b1;

        // saturation of illegal_count; no issue ever
        in_valid = 1'b1; in_instr = 32'h33; dec_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            step();
            chk("sat_start", i, 32'(start), 32'd0);
            if (i == 100 || i == 254 || i == 255 || i == 259)
                chk("sat_icnt", i, 32'(illegal_count), (i > 255) ? 32'd255 : 32'(i));
            if (i == 259) chk("sat_ill", i, 32'(illegal), 32'd1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sat_tail_start", i, 32'(start), 32'd0);
        end
        chk("sat_final_icnt", 0, 32'(illegal_count), 32'd255);
        chk("sat_final_count", 0, 32'(count), 32'd0);
        chk("sat_final_busy", 0, 32'(busy), 32'd0);
        chk("sat_final_ill", 0, 32'(illegal), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vinstr_issue_queue.md
Name: vinstr_issue_queue

Overview:
- Upstream stage of the vector decode/control top.
- Buffers 32-bit vector instructions from the host or fetch side in a small FIFO.
- Screens each instruction's major opcode, then presents legal instructions to the decoder as `vector_instruction` with a one-cycle `start` strobe.
- Paces issue with a programmable gap so the decoder/controller pipeline completes each instruction before the next arrives.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- IW, 32: instruction width.
- ISSUE_GAP, 2: idle cycles enforced after each start pulse; range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset.
- flush  input  1  synchronous clear of queue and FSM.
- in_valid  input  1  upstream instruction valid.
- in_instr  input  IW  upstream instruction.
- in_ready  output  1  queue can accept; equals !full.
- dec_ready  input  1  decoder able to take a new instruction.
- vector_instruction  output  IW  instruction presented to the decoder.
- start  output  1  one-cycle strobe; vector_instruction is valid in this cycle.
- busy  output  1  high when FSM != IDLE or count != 0.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.
- illegal  output  1  one-cycle pulse when an illegal instruction is dropped.
- illegal_count  output  8  dropped-instruction counter; saturates at 255.

Behaviour:
- Reset: sampled on a rising clk edge with rstn=0.
  - All outputs go to 0 except in_ready=1.
  - FIFO pointers and count go to 0; FSM goes to IDLE.
  - Reset has priority over everything and may occur mid-operation; any in-flight gap is abandoned.
- flush=1 (with rstn=1): same effect as reset except illegal_count is retained. flush takes priority over push and pop in the same cycle.
- Push: occurs when in_valid && in_ready at the clock edge. in_ready is derived from the registered count only, so there is no combinational path from dec_ready.
- Pop: only the FSM pops.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - A push into an empty FIFO is not bypassed.
- Legal major opcodes, in_instr[6:0]:
  - 7'b1010111 (OP-V)
  - 7'b0000111 (vector load)
  - 7'b0100111 (vector store)
- FSM states: IDLE, ISSUE, GAP.
  - IDLE: if count!=0 and dec_ready, pop the head.
    - Legal head: register it onto vector_instruction, assert start next cycle, go to ISSUE.
    - Illegal head: discard it, pulse illegal next cycle, increment illegal_count (saturating), stay in IDLE. The next entry may be examined the following cycle.
  - ISSUE: lasts exactly one cycle, with start=1.
    - ISSUE_GAP=0: go to IDLE.
    - Otherwise: load the gap counter with ISSUE_GAP and go to GAP.
  - GAP: decrement the gap counter each cycle; go to IDLE on the cycle it reaches 1.
- Hold and back-pressure:
  - vector_instruction holds its value until the next legal issue (or reset/flush to 0).
  - dec_ready low in IDLE stalls issue indefinitely; dec_ready is ignored in ISSUE and GAP.
- Latency: an instruction pushed at edge N onto an empty, idle queue with dec_ready=1 produces start high in the cycle after edge N+1, i.e. 2 cycles.
- Throughput: one legal instruction per (2 + ISSUE_GAP) cycles.
- Full: at count==DEPTH, in_ready=0. A push is impossible even if the same cycle pops; in_ready rises the cycle after the pop.
- Empty: at count==0, the FSM stays in IDLE with start=0.
- Illegal and legal instructions are both consumed in order; no reordering.

Test Plan:
- Reset mid-GAP: push 0x0000_0057, let start fire, assert rstn=0 one cycle in GAP -> next cycle start=0, vector_instruction=0, count=0, in_ready=1, busy=0.
- Single issue latency: with ISSUE_GAP=2 and dec_ready=1, push 0x0221_8057 at edge N -> start=1 in the cycle after edge N+1 with vector_instruction=0x0221_8057; busy falls 3 cycles later.
- Fill and back-pressure: dec_ready=0, push 5 instructions with DEPTH=4 -> in_ready=0 after the 4th push and count=4; then raise dec_ready -> 4 start pulses spaced 4 cycles apart, in push order, and the 5th push is accepted the cycle after the first pop.
- Illegal filtering: push 0x0000_0033, then 0x0000_0007 -> illegal pulses once and illegal_count=1; one start carries 0x0000_0007.
- Saturation: push 260 illegal opcodes -> illegal_count stops at 255 and no start is ever asserted.
- Flush with a simultaneous push: count=3, assert flush with in_valid=1 -> next cycle count=0, FSM in IDLE, start=0, illegal_count unchanged, and the pushed instruction is not stored.
